// File: rtl/pic_8259_pkg.sv
// Shared types, constants and helpers for the 8259-style interrupt controller.
// Contents: ack_state_t (IDLE/ACK_WAIT), NUM_IRQ/LVL_W, onehot_to_level,
// rotate_right, rotate_left.
package pic_8259_pkg;

  localparam int unsigned NUM_IRQ = 8;
  localparam int unsigned LVL_W   = 3;

  typedef enum logic {
    IDLE     = 1'b0,
    ACK_WAIT = 1'b1
  } ack_state_t;

  // Encode a one-hot vector; returns 0 for an all-zero vector.
  function automatic logic [LVL_W-1:0] onehot_to_level(input logic [NUM_IRQ-1:0] oh);
    logic [LVL_W-1:0] lvl;
    lvl = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (oh[i]) lvl = lvl | LVL_W'(i);
    end
    return lvl;
  endfunction

  // Result bit i takes source bit (i + amt) mod NUM_IRQ.
  function automatic logic [NUM_IRQ-1:0] rotate_right(input logic [NUM_IRQ-1:0] v,
                                                      input logic [LVL_W-1:0]   amt);
    logic [NUM_IRQ-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      r[i] = v[LVL_W'(LVL_W'(i) + amt)];
    end
    return r;
  endfunction

  // Inverse of rotate_right: source bit i moves to (i + amt) mod NUM_IRQ.
  function automatic logic [NUM_IRQ-1:0] rotate_left(input logic [NUM_IRQ-1:0] v,
                                                     input logic [LVL_W-1:0]   amt);
    logic [NUM_IRQ-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      r[LVL_W'(LVL_W'(i) + amt)] = v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/isr_priority_finder.sv
// Combinational highest-priority in-service finder.
// Scans the ISR starting at level (priority_rotate + 1) mod 8, wrapping, and
// returns the first set bit as a one-hot vector (0 when the ISR is empty).
// Ports:
//   in_service_register      in  [7:0] current ISR
//   priority_rotate          in  [2:0] lowest-priority level
//   highest_level_in_service out [7:0] one-hot winner or 0
module isr_priority_finder
  import pic_8259_pkg::*;
(
  input  logic [NUM_IRQ-1:0] in_service_register,
  input  logic [LVL_W-1:0]   priority_rotate,
  output logic [NUM_IRQ-1:0] highest_level_in_service
);

  logic [LVL_W-1:0]   start_c;
  logic [NUM_IRQ-1:0] rot_isr_c;
  logic [NUM_IRQ-1:0] lowest_c;

  // Align the highest-priority level to bit 0, isolate the lowest set bit,
  // then rotate back into absolute level positions.
  always_comb begin
    start_c   = priority_rotate + LVL_W'(1);
    rot_isr_c = rotate_right(in_service_register, start_c);
    lowest_c  = rot_isr_c & (~rot_isr_c + NUM_IRQ'(1));
    highest_level_in_service = rotate_left(lowest_c, start_c);
  end

endmodule

// File: rtl/irq_in_service_ctrl.sv
// Sequential stage around the priority resolver: captures IR lines into the
// IRR, tracks the ISR through the INTA sequence, and handles EOI commands and
// priority rotation.
// Optional macro PIC_POLL_MODE_EN adds poll_cmd / poll_word.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   ir_in                      raw IR lines (synchronous)
//   level_trigger_cfg          1=level, 0=edge capture
//   auto_eoi_cfg, auto_rotate_cfg  AEOI and rotate-on-AEOI modes
//   interrupt                  one-hot grant from resolver, or 0
//   latch_in_service, end_of_ack   INTA sequence pulses
//   nonspec_eoi, spec_eoi, eoi_level, rotate_on_eoi, set_priority  commands
//   interrupt_req_reg, in_service_register  IRR / ISR
//   highest_level_in_service   one-hot highest ISR bit (combinational)
//   priority_rotate            lowest-priority level
//   int_out                    registered INT request
//   acked_level, spurious      result of the last latch
//   ack_busy                   high in ACK_WAIT
//   poll_cmd, poll_word        poll mode (PIC_POLL_MODE_EN only)
module irq_in_service_ctrl
  import pic_8259_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] ir_in,
  input  logic               level_trigger_cfg,
  input  logic               auto_eoi_cfg,
  input  logic               auto_rotate_cfg,
  input  logic [NUM_IRQ-1:0] interrupt,
  input  logic               latch_in_service,
  input  logic               end_of_ack,
  input  logic               nonspec_eoi,
  input  logic               spec_eoi,
  input  logic [LVL_W-1:0]   eoi_level,
  input  logic               rotate_on_eoi,
  input  logic               set_priority,
`ifdef PIC_POLL_MODE_EN
  input  logic               poll_cmd,
  output logic [7:0]         poll_word,
`endif
  output logic [NUM_IRQ-1:0] interrupt_req_reg,
  output logic [NUM_IRQ-1:0] in_service_register,
  output logic [NUM_IRQ-1:0] highest_level_in_service,
  output logic [LVL_W-1:0]   priority_rotate,
  output logic               int_out,
  output logic [LVL_W-1:0]   acked_level,
  output logic               spurious,
  output logic               ack_busy
);

  ack_state_t         state_q, state_d;
  logic [NUM_IRQ-1:0] irr_q, irr_d;
  logic [NUM_IRQ-1:0] isr_q, isr_d;
  logic [NUM_IRQ-1:0] ir_prev_q;
  logic [LVL_W-1:0]   rot_q, rot_d;
  logic [LVL_W-1:0]   acked_q, acked_d;
  logic               spur_q, spur_d;
  logic               int_q;

  logic               ack_busy_c;
  logic [NUM_IRQ-1:0] hlis_c;
  logic [NUM_IRQ-1:0] ir_set_c;
  logic [NUM_IRQ-1:0] eoi_clr_c;
  logic               take_c;
  logic               eoa_c;
  logic               aeoi_c;

  assign ack_busy_c = (state_q == ACK_WAIT);

  isr_priority_finder u_finder (
    .in_service_register      (isr_q),
    .priority_rotate          (rot_q),
    .highest_level_in_service (hlis_c)
  );

  // Next-state: FSM, IRR capture, ISR set/clear and rotation arbitration.
  always_comb begin
    state_d   = state_q;
    irr_d     = irr_q;
    isr_d     = isr_q;
    rot_d     = rot_q;
    acked_d   = acked_q;
    spur_d    = spur_q;
    take_c    = 1'b0;
    eoa_c     = 1'b0;
    ir_set_c  = '0;
    eoi_clr_c = '0;
    aeoi_c    = 1'b0;

    case (state_q)
      IDLE: begin
        if (latch_in_service) begin
          take_c  = 1'b1;
          state_d = ACK_WAIT;
        end
      end
      ACK_WAIT: begin
        if (end_of_ack) begin
          eoa_c   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef PIC_POLL_MODE_EN
    // A poll is a complete latch + end-of-ack without AEOI; stay in IDLE.
    if (poll_cmd && (state_q == IDLE)) begin
      take_c  = 1'b1;
      state_d = IDLE;
    end
`endif

    // New requests are frozen during acknowledge; withdrawn lines always clear.
    if (!ack_busy_c) begin
      ir_set_c = level_trigger_cfg ? ir_in : (ir_in & ~ir_prev_q);
    end
    irr_d = (irr_q & ir_in) | ir_set_c;

    aeoi_c = eoa_c && auto_eoi_cfg && !spur_q;

    // Clears act on the pre-cycle ISR; the latch set is applied afterwards.
    if (spec_eoi) begin
      eoi_clr_c = NUM_IRQ'(1) << eoi_level;
    end else if (nonspec_eoi) begin
      eoi_clr_c = hlis_c;
    end
    if (aeoi_c) begin
      eoi_clr_c = eoi_clr_c | (NUM_IRQ'(1) << acked_q);
    end
    isr_d = isr_q & ~eoi_clr_c;

    if (take_c) begin
      if (interrupt != '0) begin
        isr_d   = isr_d | interrupt;
        irr_d   = irr_d & ~interrupt;
        acked_d = onehot_to_level(interrupt);
        spur_d  = 1'b0;
      end else begin
        acked_d = '1;
        spur_d  = 1'b1;
      end
    end

    // set_priority > EOI rotation > AEOI rotation; EOI on empty ISR is a no-op.
    if (set_priority) begin
      rot_d = eoi_level;
    end else if (rotate_on_eoi && (spec_eoi || nonspec_eoi) && (isr_q != '0)) begin
      rot_d = spec_eoi ? eoi_level : onehot_to_level(hlis_c);
    end else if (aeoi_c && auto_rotate_cfg) begin
      rot_d = acked_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      irr_q     <= '0;
      isr_q     <= '0;
      ir_prev_q <= '0;
      rot_q     <= '1;
      acked_q   <= '1;
      spur_q    <= 1'b0;
      int_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      irr_q     <= irr_d;
      isr_q     <= isr_d;
      ir_prev_q <= ir_in;
      rot_q     <= rot_d;
      acked_q   <= acked_d;
      spur_q    <= spur_d;
      int_q     <= (|interrupt) & ~ack_busy_c;
    end
  end

`ifdef PIC_POLL_MODE_EN
  logic [7:0] poll_word_q;

  // Poll result: valid flag plus encoded level of the granted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      poll_word_q <= '0;
    end else if (poll_cmd && (state_q == IDLE)) begin
      poll_word_q <= {(|interrupt), 4'b0000, onehot_to_level(interrupt)};
    end
  end

  assign poll_word = poll_word_q;
`endif

  assign interrupt_req_reg        = irr_q;
  assign in_service_register      = isr_q;
  assign highest_level_in_service = hlis_c;
  assign priority_rotate          = rot_q;
  assign int_out                  = int_q;
  assign acked_level              = acked_q;
  assign spurious                 = spur_q;
  assign ack_busy                 = ack_busy_c;

endmodule

// File: tb/tb_irq_in_service_ctrl.sv
// Bench for irq_in_service_ctrl: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a behavioural model.
module tb_irq_in_service_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] ir_in;
  logic       level_trigger_cfg;
  logic       auto_eoi_cfg;
  logic       auto_rotate_cfg;
  logic [7:0] interrupt;
  logic       latch_in_service;
  logic       end_of_ack;
  logic       nonspec_eoi;
  logic       spec_eoi;
  logic [2:0] eoi_level;
  logic       rotate_on_eoi;
  logic       set_priority;
  logic [7:0] interrupt_req_reg;
  logic [7:0] in_service_register;
  logic [7:0] highest_level_in_service;
  logic [2:0] priority_rotate;
  logic       int_out;
  logic [2:0] acked_level;
  logic       spurious;
  logic       ack_busy;

  irq_in_service_ctrl dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .ir_in                    (ir_in),
    .level_trigger_cfg        (level_trigger_cfg),
    .auto_eoi_cfg             (auto_eoi_cfg),
    .auto_rotate_cfg          (auto_rotate_cfg),
    .interrupt                (interrupt),
    .latch_in_service         (latch_in_service),
    .end_of_ack               (end_of_ack),
    .nonspec_eoi              (nonspec_eoi),
    .spec_eoi                 (spec_eoi),
    .eoi_level                (eoi_level),
    .rotate_on_eoi            (rotate_on_eoi),
    .set_priority             (set_priority),
    .interrupt_req_reg        (interrupt_req_reg),
    .in_service_register      (in_service_register),
    .highest_level_in_service (highest_level_in_service),
    .priority_rotate          (priority_rotate),
    .int_out                  (int_out),
    .acked_level              (acked_level),
    .spurious                 (spurious),
    .ack_busy                 (ack_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_bad = 0;

  // Model state (value of each register after the last rising edge).
  logic [7:0] m_irr, m_isr, m_prev;
  int         m_rot, m_acked;
  bit         m_spur, m_int, m_busy;
  logic [7:0] n_irr, n_isr, n_prev;
  int         n_rot, n_acked;
  bit         n_spur, n_int, n_busy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Highest in-service level: walk levels rot+1, rot+2, ... modulo 8.
  function automatic logic [7:0] ref_hlis(input logic [7:0] isr, input int rot);
    int lv;
    for (int k = 1; k <= 8; k++) begin
      lv = (rot + k) % 8;
      if (isr[lv]) return 8'(1 << lv);
    end
    return 8'h00;
  endfunction

  function automatic int lvl_of(input logic [7:0] oh);
    for (int i = 0; i < 8; i++) if (oh[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_irr = 8'h00; m_isr = 8'h00; m_prev = 8'h00;
    m_rot = 7; m_acked = 7; m_spur = 0; m_int = 0; m_busy = 0;
  endtask

  task automatic model_next();
    logic [7:0] h, setm;
    int eoi_rot, aeoi_rot;
    h = ref_hlis(m_isr, m_rot);
    setm = level_trigger_cfg ? ir_in : (ir_in & ~m_prev);
    if (m_busy) setm = 8'h00;
    n_irr  = (m_irr & ir_in) | setm;
    n_prev = ir_in;
    n_int  = (interrupt != 8'h00) && !m_busy;
    n_isr = m_isr; n_rot = m_rot; n_acked = m_acked; n_spur = m_spur; n_busy = m_busy;
    eoi_rot = -1;
    aeoi_rot = -1;
    if (spec_eoi) begin
      n_isr[eoi_level] = 1'b0;
      if (rotate_on_eoi && m_isr != 8'h00) eoi_rot = int'(eoi_level);
    end else if (nonspec_eoi && m_isr != 8'h00) begin
      n_isr = n_isr & ~h;
      if (rotate_on_eoi) eoi_rot = lvl_of(h);
    end
    if (m_busy && end_of_ack) begin
      n_busy = 0;
      if (auto_eoi_cfg && !m_spur) begin
        n_isr[m_acked] = 1'b0;
        if (auto_rotate_cfg) aeoi_rot = m_acked;
      end
    end
    if (!m_busy && latch_in_service) begin
      n_busy = 1;
      if (interrupt != 8'h00) begin
        n_isr   = n_isr | interrupt;
        n_irr   = n_irr & ~interrupt;
        n_acked = lvl_of(interrupt);
        n_spur  = 0;
      end else begin
        n_acked = 7;
        n_spur  = 1;
      end
    end
    if (set_priority)       n_rot = int'(eoi_level);
    else if (eoi_rot >= 0)  n_rot = eoi_rot;
    else if (aeoi_rot >= 0) n_rot = aeoi_rot;
  endtask

  task automatic check_all();
    chk("irr",   interrupt_req_reg, m_irr);
    chk("isr",   in_service_register, m_isr);
    chk("hlis",  highest_level_in_service, ref_hlis(m_isr, m_rot));
    chk("rot",   priority_rotate, m_rot);
    chk("int",   int_out, m_int);
    chk("acked", acked_level, m_acked);
    chk("spur",  spurious, m_spur);
    chk("busy",  ack_busy, m_busy);
  endtask

  // One clock: inputs are already set (at negedge); pulses clear afterwards.
  task automatic cyc();
    model_next();
    @(posedge clk);
    #1;
    m_irr = n_irr; m_isr = n_isr; m_prev = n_prev; m_rot = n_rot;
    m_acked = n_acked; m_spur = n_spur; m_int = n_int; m_busy = n_busy;
    check_all();
    @(negedge clk);
    latch_in_service = 0; end_of_ack = 0; nonspec_eoi = 0; spec_eoi = 0;
    set_priority = 0; rotate_on_eoi = 0;
  endtask

  // Called at a negedge; holds reset across one rising edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all();
    chk("rst_isr", in_service_register, 8'h00);
    chk("rst_rot", priority_rotate, 3'd7);
    chk("rst_acked", acked_level, 3'd7);
    chk("rst_busy", ack_busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; ir_in = 8'h00; level_trigger_cfg = 0; auto_eoi_cfg = 0;
    auto_rotate_cfg = 0; interrupt = 8'h00; latch_in_service = 0; end_of_ack = 0;
    nonspec_eoi = 0; spec_eoi = 0; eoi_level = 3'd0; rotate_on_eoi = 0; set_priority = 0;
    @(negedge clk);
    do_reset();

    // Edge capture and full non-AEOI acknowledge of IR3.
    ir_in = 8'h08; cyc();
    chk("t1_irr_set", interrupt_req_reg, 8'h08);
    interrupt = 8'h08; cyc();
    chk("t1_int_on", int_out, 1'b1);
    latch_in_service = 1; cyc();
    chk("t1_isr", in_service_register, 8'h08);
    chk("t1_irr_clr", interrupt_req_reg, 8'h00);
    chk("t1_acked", acked_level, 3'd3);
    cyc();
    chk("t1_int_off", int_out, 1'b0);
    interrupt = 8'h00; end_of_ack = 1; cyc();
    chk("t1_idle", ack_busy, 1'b0);
    chk("t1_isr_kept", in_service_register, 8'h08);
    ir_in = 8'h00; cyc();

    // Non-specific EOI with rotation on ISR=0x0A.
    do_reset();
    interrupt = 8'h02; latch_in_service = 1; cyc();
    interrupt = 8'h00; end_of_ack = 1; cyc();
    interrupt = 8'h08; latch_in_service = 1; cyc();
    interrupt = 8'h00; end_of_ack = 1; cyc();
    chk("t2_isr_pre", in_service_register, 8'h0A);
    nonspec_eoi = 1; rotate_on_eoi = 1; cyc();
    chk("t2_isr", in_service_register, 8'h08);
    chk("t2_rot", priority_rotate, 3'd1);

    // AEOI with auto-rotate on IR6.
    do_reset();
    auto_eoi_cfg = 1; auto_rotate_cfg = 1;
    interrupt = 8'h40; latch_in_service = 1; cyc();
    interrupt = 8'h00; end_of_ack = 1; cyc();
    chk("t3_isr", in_service_register, 8'h00);
    chk("t3_rot", priority_rotate, 3'd6);
    auto_eoi_cfg = 0; auto_rotate_cfg = 0;

    // Spurious latch leaves ISR intact.
    do_reset();
    interrupt = 8'h08; latch_in_service = 1; cyc();
    interrupt = 8'h00; end_of_ack = 1; cyc();
    latch_in_service = 1; cyc();
    chk("t4_acked", acked_level, 3'd7);
    chk("t4_spur", spurious, 1'b1);
    chk("t4_isr", in_service_register, 8'h08);
    end_of_ack = 1; cyc();

    // Level mode: drop IR0 and raise IR2 during ACK_WAIT.
    do_reset();
    level_trigger_cfg = 1; ir_in = 8'h01; cyc();
    chk("t5_irr_lvl", interrupt_req_reg, 8'h01);
    interrupt = 8'h01; latch_in_service = 1; cyc();
    interrupt = 8'h00; ir_in = 8'h04; cyc();
    chk("t5_irr_frozen", interrupt_req_reg, 8'h00);
    end_of_ack = 1; cyc();
    chk("t5_irr_still", interrupt_req_reg, 8'h00);
    cyc();
    chk("t5_irr_idle", interrupt_req_reg, 8'h04);
    level_trigger_cfg = 0; ir_in = 8'h00; cyc();

    // Reset in the middle of an acknowledge.
    do_reset();
    interrupt = 8'h10; latch_in_service = 1; cyc();
    chk("t6_isr", in_service_register, 8'h10);
    chk("t6_busy", ack_busy, 1'b1);
    interrupt = 8'h00;
    do_reset();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if (n % 250 == 0) begin
        level_trigger_cfg = 1'($urandom_range(1));
        auto_eoi_cfg      = 1'($urandom_range(1));
        auto_rotate_cfg   = 1'($urandom_range(1));
      end
      if (n % 700 == 699) do_reset();
      ir_in = ir_in ^ 8'($urandom() & $urandom() & $urandom());
      interrupt = ($urandom_range(1) == 0) ? 8'h00 : 8'(1 << $urandom_range(7));
      latch_in_service = ($urandom_range(99) < 15);
      end_of_ack       = ($urandom_range(99) < 20);
      nonspec_eoi      = ($urandom_range(99) < 8);
      spec_eoi         = ($urandom_range(99) < 8);
      rotate_on_eoi    = ($urandom_range(99) < 50);
      set_priority     = ($urandom_range(99) < 3);
      eoi_level        = 3'($urandom_range(7));
      cyc();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
